// File: rtl/smc_pkg.sv
// Shared types, widths and the weighted-sum helper for the serial SMC sequencing engine.
package smc_pkg;
    localparam int unsigned N_MOS = 6;
    localparam int unsigned CW    = 3;
    localparam int unsigned FW    = 3;
    localparam int unsigned DW    = 8;
    localparam int unsigned OW    = 10;
    localparam int unsigned VT    = 1;
    localparam int unsigned K     = 3;

    typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;

    typedef enum logic [1:0] {
        MODE_LOW_SUM   = 2'b00,
        MODE_LOW_WSUM  = 2'b01,
        MODE_HIGH_SUM  = 2'b10,
        MODE_HIGH_WSUM = 2'b11
    } mode_t;

    typedef struct packed {
        logic [FW-1:0] w;
        logic [FW-1:0] vgs;
        logic [FW-1:0] vds;
    } mos_t;

    // Plain or 3/4/5-weighted sum of three sorted entries
    function automatic logic [OW-1:0] sum3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] c, input logic weighted);
        if (weighted)
            return OW'(3) * OW'(a) + OW'(4) * OW'(b) + OW'(5) * OW'(c);
        else
            return OW'(a) + OW'(b) + OW'(c);
    endfunction
endpackage

// File: rtl/smc_seq_engine_if.sv
// Beat-input / result-output bus of smc_seq_engine; out_err exists only with SMC_SEQ_CHK_EN.
interface smc_seq_engine_if;
    import smc_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [1:0]    mode;
    logic [FW-1:0] w;
    logic [FW-1:0] vgs;
    logic [FW-1:0] vds;
    logic          out_valid;
    logic [OW-1:0] out_n;
`ifdef SMC_SEQ_CHK_EN
    logic          out_err;

    modport master (output in_valid, mode, w, vgs, vds,
                    input  in_ready, out_valid, out_n, out_err);
    modport slave  (input  in_valid, mode, w, vgs, vds,
                    output in_ready, out_valid, out_n, out_err);
`else
    modport master (output in_valid, mode, w, vgs, vds,
                    input  in_ready, out_valid, out_n);
    modport slave  (input  in_valid, mode, w, vgs, vds,
                    output in_ready, out_valid, out_n);
`endif
endinterface

// File: rtl/smc_mos_calc.sv
// Combinational MOSFET drain current / transconductance calculator (floor division by K).
module smc_mos_calc
    import smc_pkg::*;
(
    input  mos_t          mos,
    output logic [DW-1:0] id,
    output logic [DW-1:0] gm
);
    localparam int unsigned IW = 12;

    logic [IW-1:0] w_x;
    logic [IW-1:0] vgs_x;
    logic [IW-1:0] vds_x;
    logic [IW-1:0] ov;
    logic [IW-1:0] id_num;
    logic [IW-1:0] gm_num;

    always_comb begin
        w_x   = IW'(mos.w);
        vgs_x = IW'(mos.vgs);
        vds_x = IW'(mos.vds);
        // Overdrive clamps at zero below threshold
        ov    = (vgs_x < IW'(VT)) ? '0 : vgs_x - IW'(VT);
        if (ov > vds_x) begin
            id_num = w_x * (IW'(2) * ov * vds_x - vds_x * vds_x);
            gm_num = IW'(2) * w_x * vds_x;
        end else begin
            id_num = w_x * ov * ov;
            gm_num = IW'(2) * w_x * ov;
        end
        id = DW'(id_num / IW'(K));
        gm = DW'(gm_num / IW'(K));
    end
endmodule

// File: rtl/smc_seq_engine.sv
// Serial SMC engine: six beats -> per-beat ID/gm -> descending insertion sort -> weighted sum.
// Optional SMC_SEQ_CHK_EN adds a sticky per-frame zero-field flag on out_err.
module smc_seq_engine
    import smc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    smc_seq_engine_if.slave    bus
);
    state_t        state_q, state_d;
    logic [CW-1:0] count_q;
    logic [DW-1:0] buf_q   [N_MOS];
    logic [DW-1:0] buf_ins [N_MOS];
    logic [1:0]    mode_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic [OW-1:0] out_n_q;

    logic             accept;
    logic [1:0]       mode_eff;
    logic [DW-1:0]    id_v;
    logic [DW-1:0]    gm_v;
    logic [DW-1:0]    ins_val;
    logic [N_MOS-1:0] ge;
    logic [OW-1:0]    sum;

    assign accept   = bus.in_valid && in_ready_q;
    // The frame's first beat must use the mode presented with it, not the stale copy
    assign mode_eff = (state_q == IDLE) ? bus.mode : mode_q;
    assign ins_val  = mode_eff[0] ? id_v : gm_v;

    smc_mos_calc u_calc (
        .mos ('{w: bus.w, vgs: bus.vgs, vds: bus.vds}),
        .id  (id_v),
        .gm  (gm_v)
    );

    // Parallel compare/shift: new value lands below all existing entries >= it
    always_comb begin
        for (int i = 0; i < N_MOS; i++)
            ge[i] = (CW'(i) < count_q) && (buf_q[i] >= ins_val);
        buf_ins[0] = ge[0] ? buf_q[0] : ins_val;
        for (int i = 1; i < N_MOS; i++) begin
            if (ge[i])
                buf_ins[i] = buf_q[i];
            else if (ge[i-1])
                buf_ins[i] = ins_val;
            else
                buf_ins[i] = buf_q[i-1];
        end
    end

    always_comb begin
        sum = '0;
        case (mode_t'(mode_q))
            MODE_LOW_SUM:   sum = sum3(buf_q[3], buf_q[4], buf_q[5], 1'b0);
            MODE_LOW_WSUM:  sum = sum3(buf_q[3], buf_q[4], buf_q[5], 1'b1);
            MODE_HIGH_SUM:  sum = sum3(buf_q[0], buf_q[1], buf_q[2], 1'b0);
            MODE_HIGH_WSUM: sum = sum3(buf_q[0], buf_q[1], buf_q[2], 1'b1);
            default:        sum = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = LOAD;
            LOAD:    if (accept && count_q == CW'(N_MOS - 1)) state_d = CALC;
            CALC:    state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            buf_q       <= '{default: '0};
            mode_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_n_q     <= '0;
        end else begin
            in_ready_q  <= (state_d == IDLE) || (state_d == LOAD);
            out_valid_q <= (state_q == CALC);
            out_n_q     <= (state_q == CALC) ? sum : '0;
            if (accept) begin
                buf_q   <= buf_ins;
                count_q <= count_q + CW'(1);
                if (state_q == IDLE)
                    mode_q <= bus.mode;
            end
            // Stale entries must never leak into the next frame
            if (state_q == OUT) begin
                buf_q   <= '{default: '0};
                count_q <= '0;
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_n     = out_n_q;

`ifdef SMC_SEQ_CHK_EN
    logic err_q;
    logic out_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q     <= 1'b0;
            out_err_q <= 1'b0;
        end else begin
            out_err_q <= (state_q == CALC) ? err_q : 1'b0;
            if (accept && (bus.w == '0 || bus.vgs == '0 || bus.vds == '0))
                err_q <= 1'b1;
            if (state_q == OUT)
                err_q <= 1'b0;
        end
    end

    assign bus.out_err = out_err_q;
`endif
endmodule

// File: tb/tb_smc_seq_engine.sv
// Scoreboard bench for smc_seq_engine: directed frames plus randomized frames against a reference model.
module tb_smc_seq_engine;
    import smc_pkg::*;

    typedef struct {
        int val;
        int cyc;
        int err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    smc_seq_engine_if bus ();

    smc_seq_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    exp_t sb[$];
    exp_t e;
    int   frame_vals[$];
    int   fmode      = 0;
    int   ferr       = 0;
    int   busy       = 0;
    bit   last_acc   = 1'b0;

    int t2w[6] = '{1, 2, 3, 4, 5, 6};
    int t2g[6] = '{2, 3, 4, 5, 6, 7};
    int t3w[6] = '{5, 2, 7, 3, 6, 4};
    int t3g[6] = '{6, 3, 7, 5, 2, 4};
    int t3d[6] = '{2, 1, 3, 5, 1, 2};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: spec equations on plain integers
    function automatic int ref_value(input int w, input int vgs, input int vds, input int m);
        int ov;
        int id;
        int gm;
        ov = (vgs == 0) ? 0 : vgs - 1;
        if (ov > vds) begin
            id = w * (2 * ov * vds - vds * vds) / 3;
            gm = 2 * w * vds / 3;
        end else begin
            id = w * ov * ov / 3;
            gm = 2 * w * ov / 3;
        end
        return (m % 2 == 1) ? id : gm;
    endfunction

    function automatic int ref_result(input int vals[$], input int m);
        int q[$];
        int a;
        int b;
        int c;
        q = vals;
        q.rsort();
        if (m >= 2) begin a = q[0]; b = q[1]; c = q[2]; end
        else        begin a = q[3]; b = q[4]; c = q[5]; end
        return (m % 2 == 1) ? 3 * a + 4 * b + 5 * c : a + b + c;
    endfunction

    // One cycle of stimulus; called at posedge+1, returns at the next posedge+1
    task automatic beat(input bit v, input int m, input int w, input int vgs, input int vds);
        bit acc;
        bus.in_valid = v;
        bus.mode     = 2'(m);
        bus.w        = 3'(w);
        bus.vgs      = 3'(vgs);
        bus.vds      = 3'(vds);
        check("in_ready", int'(bus.in_ready), int'(busy == 0));
        acc = v && (busy == 0);
        @(posedge clk);
        #1;
        if (busy > 0) busy--;
        last_acc = acc;
        if (acc) begin
            if (frame_vals.size() == 0) begin
                fmode = m;
                ferr  = 0;
            end
            frame_vals.push_back(ref_value(w, vgs, vds, fmode));
            if (w == 0 || vgs == 0 || vds == 0) ferr = 1;
            if (frame_vals.size() == N_MOS) begin
                sb.push_back('{ref_result(frame_vals, fmode), cyc + 1, ferr});
                frame_vals.delete();
                busy = 2;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            beat(1'b0, $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7));
    endtask

    // Randomized frame; beats offered while busy are dropped by the design and the model
    task automatic send_frame(input int m, input int gap_pct, input bit hold, input bit nz);
        int got;
        int guard;
        int lo;
        bit v;
        got   = 0;
        guard = 0;
        lo    = nz ? 1 : 0;
        while (got < N_MOS && guard < 200) begin
            v = ($urandom_range(0, 99) >= gap_pct) || (hold && busy != 0);
            beat(v, m, $urandom_range(lo, 7), $urandom_range(lo, 7), $urandom_range(lo, 7));
            if (last_acc) got++;
            guard++;
        end
        if (got < N_MOS) check("frame_timeout", got, N_MOS);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("out_n", int'(bus.out_n), e.val);
                    check("latency", cyc, e.cyc);
`ifdef SMC_SEQ_CHK_EN
                    check("out_err", int'(bus.out_err), e.err);
`endif
                end
            end else begin
                check("out_n_idle", int'(bus.out_n), 0);
`ifdef SMC_SEQ_CHK_EN
                check("out_err_idle", int'(bus.out_err), 0);
`endif
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.mode     = '0;
        bus.w        = '0;
        bus.vgs      = '0;
        bus.vds      = '0;
        rst          = 1'b1;
        #1;
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_n", int'(bus.out_n), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // T1: identical triode beats, mode 11
        for (int i = 0; i < N_MOS; i++) beat(1'b1, 3, 7, 7, 1);
        idle(4);

        // T2: saturation/triode mix, mode 10
        for (int i = 0; i < N_MOS; i++) beat(1'b1, 2, t2w[i], t2g[i], 1);
        idle(4);

        // T3: same tuples with and without gaps, mode 00
        for (int i = 0; i < N_MOS; i++) beat(1'b1, 0, t3w[i], t3g[i], t3d[i]);
        idle(3);
        for (int i = 0; i < N_MOS; i++) begin
            beat(1'b1, 0, t3w[i], t3g[i], t3d[i]);
            if (i < N_MOS - 1) idle($urandom_range(1, 3));
        end
        idle(4);

        // T4: reset mid-frame, then a full frame
        for (int i = 0; i < 3; i++) beat(1'b1, 3, 6, 7, 2);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", int'(bus.in_ready), 1);
        check("midrst_out_valid", int'(bus.out_valid), 0);
        check("midrst_out_n", int'(bus.out_n), 0);
        frame_vals.delete();
        busy = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_frame(1, 0, 1'b0, 1'b1);
        idle(4);

        // T5: back-to-back frames with in_valid held high
        send_frame(1, 0, 1'b1, 1'b0);
        send_frame(3, 0, 1'b1, 1'b0);
        idle(4);

        // T6: a zero field then a clean frame
        for (int i = 0; i < N_MOS; i++) beat(1'b1, 3, 5, (i == 2) ? 0 : 6, 2);
        idle(3);
        send_frame(3, 0, 1'b0, 1'b1);
        idle(4);

        // Randomized frames
        for (int f = 0; f < 40; f++)
            send_frame($urandom_range(0, 3), $urandom_range(0, 40), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));

        for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
        if (sb.size() != 0) check("drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
